opti_result_buf: RTL
====================

// Module: opti_result_buf
// PURPOSE
// - Downstream capture stage for the 4-section IIR filter top: stores each filtered Q2.22 sample at its output address.
// - After filter_done, streams the captured block back out over a valid/ready read port, in address order 0..N-1.
// - Also latches the end-of-run stable flag, and optionally the peak magnitude, for the test host.
// PARAMETERS
// - DATA_W   24    sample width, Q2.22 signed
// - ADDR_W   11    address width, matches the filter output addr
// - DEPTH    2048  buffer entries; must equal 2**ADDR_W
// PORTS
// - clk            in   1       single clock, rising edge
// - rst_n          in   1       reset, synchronous, active-low
// - wr_valid       in   1       filtered sample strobe (from data_out_valid)
// - wr_addr        in   ADDR_W  write address (from addr)
// - wr_data        in   DATA_W  filtered sample, Q2.22
// - filter_done    in   1       single-cycle end-of-run pulse
// - stable_in      in   1       filter stability flag
// - rd_start       in   1       begin readout; honoured only in DONE
// - rd_ready       in   1       consumer accepts the current beat
// - rd_valid       out  1       rd_data/rd_addr/rd_last are valid
// - rd_data        out  DATA_W  readout sample
// - rd_addr        out  ADDR_W  address of the readout sample
// - rd_last        out  1       final beat of readout (index sample_cnt-1)
// - sample_cnt     out  ADDR_W+1  accepted writes this run, saturates at DEPTH
// - buf_full       out  1       sample_cnt == DEPTH
// - overflow       out  1       sticky: write refused (full, DONE or READOUT)
// - stable_latched out  1       stable_in sampled on filter_done
// - peak_abs       out  DATA_W  max |wr_data| this run (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge): state IDLE; all outputs 0; RAM contents not cleared. This applies mid-readout too: rd_valid is 0 from the next cycle.
// - States:
//   - IDLE: the first wr_valid clears sample_cnt, overflow and peak_abs, writes the sample (count=1) and moves to CAPTURE.
//   - CAPTURE: each wr_valid writes RAM[wr_addr] and sample_cnt++. filter_done -> DONE.
//   - DONE: rd_start -> READOUT. If sample_cnt==0, rd_start -> IDLE instead, and no beats are produced.
//   - READOUT: after the rd_last beat is accepted, the block returns to IDLE.
// - filter_done in IDLE (no samples written): latch stable, go to DONE with sample_cnt=0.
// - wr_valid and filter_done in the same cycle: the sample is accepted and counted, then the state moves to DONE.
// - Write when sample_cnt==DEPTH: no RAM write, count holds, overflow<=1.
// - wr_valid in DONE or READOUT: ignored, overflow<=1.
// - rd_start outside DONE is ignored.
// - stable_latched <= stable_in on the filter_done cycle. It holds until the next filter_done or reset.
// - Readout path:
//   - RAM read latency is 1 cycle, followed by a 1-entry output register.
//   - The first rd_valid appears 2 cycles after rd_start is sampled.
//   - A beat transfers when rd_valid && rd_ready. With rd_ready held 1, one beat per cycle and no bubbles.
//   - While rd_valid && !rd_ready, rd_data/rd_addr/rd_last hold stable. No RAM read is lost or repeated (skid handling is required).
//   - rd_valid does not depend combinationally on rd_ready.
// - Read index runs 0..sample_cnt-1 with no wrap. rd_addr equals the read index.
// - Counters saturate, never wrap. buf_full is combinational from sample_cnt.
// CONFIGURATION
// - Macro OPTI_RESULT_PEAK_EN, defined:
//   - On each accepted write, peak_abs <= max(peak_abs, |wr_data|).
//   - |0x800000| saturates to 0x7FFFFF.
//   - peak_abs clears at capture start.
// - Macro not defined: the peak logic is not built and peak_abs is tied to 0. The port list is identical in both builds.
// TESTING
// - Write 0x000001,0x000002,0xFFFFFF,0x400000 at addr 0..3; filter_done; rd_start; rd_ready=1 -> rd_valid 2 cycles after rd_start; data in that order; rd_last on beat 4; then IDLE.
// - As above, but drop rd_ready for 3 cycles after beat 2 -> beat-2 outputs held unchanged; beats 3,4 follow with no loss or duplication.
// - 2049 writes to addr 0..2047,0 -> sample_cnt=2048, buf_full=1, overflow=1, RAM[0] keeps the first value.
// - wr_valid with filter_done in the same cycle (stable_in=1) as the 3rd sample -> sample_cnt=3, stable_latched=1, DONE; a later wr_valid sets overflow.
// - With OPTI_RESULT_PEAK_EN defined: write 0x200000, 0xC00000, 0x800000 -> peak_abs 0x200000, 0x400000, 0x7FFFFF. Undefined -> peak_abs stays 0.
// - Assert rst_n=0 for 1 cycle mid-readout -> next cycle rd_valid=0, all outputs 0, state IDLE; rd_start then ignored; filter_done with no writes -> DONE, rd_start -> IDLE, no beats.

Source files
------------

// File: rtl/opti_result_buf.sv
// opti_result_buf: capture buffer behind the 4-section IIR filter.
// Stores each filtered Q2.22 sample at its output address. After
// filter_done it streams the block back in address order 0..N-1 over a
// valid/ready port. It also latches the end-of-run stable flag.
// Optional build macro OPTI_RESULT_PEAK_EN adds a running peak-magnitude
// tracker. Without it, peak_abs is tied to zero and the ports are unchanged.
module opti_result_buf #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              filter_done,
    input  logic              stable_in,
    input  logic              rd_start,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last,
    output logic [ADDR_W:0]   sample_cnt,
    output logic              buf_full,
    output logic              overflow,
    output logic              stable_latched,
    output logic [DATA_W-1:0] peak_abs
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic              overflow_q;
    logic              stable_q;

    // Sample storage; never reset so it maps onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;

    // Readout pipeline: issue counter -> RAM stage -> output register.
    logic [CNT_W-1:0]  issue_q;
    logic              s1_valid_q;
    logic              s1_last_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_data_q;

    // Control strobes decoded from the state.
    logic full;
    logic wr_accept;
    logic cap_start;
    logic cnt_clear;
    logic ovf_set;
    logic rd_begin;
    logic rd_issue;
    logic out_ready;
    logic s1_ready;
    logic last_taken;

    assign full       = (cnt_q == DEPTH_C);
    // Each stage may load when it is empty or its content moves on this cycle.
    // The RAM read enable therefore stalls in step with the consumer. A
    // stalled beat keeps its data in place, so no read is lost or repeated.
    assign out_ready  = !out_valid_q || rd_ready;
    assign s1_ready   = !s1_valid_q || out_ready;
    assign last_taken = out_valid_q && rd_ready && out_last_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (filter_done) begin
                    state_d = S_DONE;
                end else if (wr_valid) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (filter_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (rd_start) begin
                    state_d = (cnt_q == '0) ? S_IDLE : S_READOUT;
                end
            end
            S_READOUT: begin
                if (last_taken) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-state control strobes for capture, overflow and readout.
    always_comb begin
        wr_accept = 1'b0;
        cap_start = 1'b0;
        cnt_clear = 1'b0;
        ovf_set   = 1'b0;
        rd_begin  = 1'b0;
        rd_issue  = 1'b0;
        case (state_q)
            S_IDLE: begin
                wr_accept = wr_valid;
                cap_start = wr_valid;
                cnt_clear = filter_done && !wr_valid;
            end
            S_CAPTURE: begin
                wr_accept = wr_valid && !full;
                ovf_set   = wr_valid && full;
            end
            S_DONE: begin
                ovf_set  = wr_valid;
                rd_begin = rd_start && (cnt_q != '0);
            end
            S_READOUT: begin
                ovf_set  = wr_valid;
                rd_issue = (issue_q < cnt_q) && s1_ready;
            end
            default: ;
        endcase
    end

    // Sample counter: restarts at 1 on the first write of a run and saturates at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clear) begin
            cnt_q <= '0;
        end else if (cap_start) begin
            cnt_q <= ONE_C;
        end else if (wr_accept) begin
            cnt_q <= cnt_q + ONE_C;
        end
    end

    // Sticky overflow flag, cleared only when a new capture starts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (cap_start) begin
            overflow_q <= 1'b0;
        end else if (ovf_set) begin
            overflow_q <= 1'b1;
        end
    end

    // Stability flag is captured on every filter_done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable_q <= 1'b0;
        end else if (filter_done) begin
            stable_q <= stable_in;
        end
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // RAM read port, with a read enable so that stalls hold the data.
    always_ff @(posedge clk) begin
        if (rd_issue) begin
            ram_q <= mem[issue_q[ADDR_W-1:0]];
        end
    end

    // Read index and the RAM-stage tag (address and last flag).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_addr_q  <= '0;
        end else begin
            if (rd_begin) begin
                issue_q <= '0;
            end else if (rd_issue) begin
                issue_q <= issue_q + ONE_C;
            end
            if (s1_ready) begin
                s1_valid_q <= rd_issue;
                if (rd_issue) begin
                    s1_addr_q <= issue_q[ADDR_W-1:0];
                    s1_last_q <= (issue_q == cnt_q - ONE_C);
                end
            end
        end
    end

    // Output register; it holds its beat while the consumer is not ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else if (out_ready) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= ram_q;
                out_addr_q <= s1_addr_q;
                out_last_q <= s1_last_q;
            end
        end
    end

`ifdef OPTI_RESULT_PEAK_EN
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

    logic [DATA_W-1:0] wr_abs;
    logic [DATA_W-1:0] peak_q;

    // Magnitude of the incoming sample. The most negative code saturates
    // because its magnitude cannot be represented.
    always_comb begin
        if (!wr_data[DATA_W-1]) begin
            wr_abs = wr_data;
        end else if (wr_data == MOST_NEG) begin
            wr_abs = MOST_POS;
        end else begin
            wr_abs = -wr_data;
        end
    end

    // Running peak: restarts with the first sample of a run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else if (cap_start) begin
            peak_q <= wr_abs;
        end else if (wr_accept && (wr_abs > peak_q)) begin
            peak_q <= wr_abs;
        end
    end

    assign peak_abs = peak_q;
`else
    assign peak_abs = '0;
`endif

    assign rd_valid       = out_valid_q;
    assign rd_data        = out_data_q;
    assign rd_addr        = out_addr_q;
    assign rd_last        = out_last_q;
    assign sample_cnt     = cnt_q;
    assign buf_full       = full;
    assign overflow       = overflow_q;
    assign stable_latched = stable_q;

endmodule
